// File: rtl/rf8_4b_host_ctrl_if.sv
// Client-side command and response channels of the 8x4 register-file controller.
// The client drives through master; the controller sits on slave.
interface rf8_4b_host_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [2:0] cmd_addr;
    logic [3:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rf8_4b_host_ctrl.sv
// Owns every port of an 8-entry x 4-bit register file: optional clear sweep after
// reset, then one client read or write at a time with a held read response.
module rf8_4b_host_ctrl #(
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [3:0] INIT_VAL       = 4'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    rf8_4b_host_ctrl_if.slave         bus,
    output logic                      init_busy,
    output logic [2:0]                rf_wrAddr,
    output logic [3:0]                rf_wrVal,
    output logic                      rf_wrEn,
    output logic [2:0]                rf_rdAddr,
    input  logic [3:0]                rf_rdVal
);
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [3:0] rsp_data_q, rsp_data_d;
    logic       init_busy_q, init_busy_d;
    logic       wr_en_q, wr_en_d;
    logic [2:0] wr_addr_q, wr_addr_d;
    logic [3:0] wr_val_q, wr_val_d;
    logic [2:0] rd_addr_q, rd_addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
            cnt_q       <= 3'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 4'h0;
            init_busy_q <= CLEAR_ON_RESET;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 3'd0;
            wr_val_q    <= 4'h0;
            rd_addr_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            init_busy_q <= init_busy_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_val_q    <= wr_val_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        init_busy_d = init_busy_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_val_d    = wr_val_q;
        rd_addr_d   = rd_addr_q;

        case (state_q)
            ST_INIT: begin
                // A pending write with cnt back at 0 means entry 7 was just issued.
                if (wr_en_q && cnt_q == 3'd0) begin
                    init_busy_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = cnt_q;
                    wr_val_d    = INIT_VAL;
                    cnt_d       = cnt_q + 3'd1;
                    init_busy_d = 1'b1;
                end
            end
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (bus.cmd_wr) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = bus.cmd_addr;
                        wr_val_d  = bus.cmd_data;
                        state_d   = ST_WRITE;
                    end else begin
                        rd_addr_d = bus.cmd_addr;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_READ: begin
                rsp_data_d  = rf_rdVal;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                init_busy_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign init_busy     = init_busy_q;
    assign rf_wrEn       = wr_en_q;
    assign rf_wrAddr     = wr_addr_q;
    assign rf_wrVal      = wr_val_q;
    assign rf_rdAddr     = rd_addr_q;
endmodule

// File: tb/tb_rf8_4b_host_ctrl.sv
// Directed bench for rf8_4b_host_ctrl: a cleared instance (INIT_VAL=5) driven through
// reads, writes, stalls and resets, plus a no-clear instance checked for immediate readiness.
module tb_rf8_4b_host_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst0 = 1'b1;
    always #5 clk = ~clk;

    rf8_4b_host_ctrl_if bus ();
    rf8_4b_host_ctrl_if bus0 ();

    logic       init_busy, rf_wrEn;
    logic [2:0] rf_wrAddr, rf_rdAddr;
    logic [3:0] rf_wrVal, rf_rdVal;
    logic       init_busy0, rf_wrEn0;
    logic [2:0] rf_wrAddr0, rf_rdAddr0;
    logic [3:0] rf_wrVal0, rf_rdVal0;

    rf8_4b_host_ctrl #(.CLEAR_ON_RESET(1'b1), .INIT_VAL(4'h5)) dut (
        .clk(clk), .rst(rst), .bus(bus), .init_busy(init_busy),
        .rf_wrAddr(rf_wrAddr), .rf_wrVal(rf_wrVal), .rf_wrEn(rf_wrEn),
        .rf_rdAddr(rf_rdAddr), .rf_rdVal(rf_rdVal)
    );

    rf8_4b_host_ctrl #(.CLEAR_ON_RESET(1'b0), .INIT_VAL(4'h5)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0), .init_busy(init_busy0),
        .rf_wrAddr(rf_wrAddr0), .rf_wrVal(rf_wrVal0), .rf_wrEn(rf_wrEn0),
        .rf_rdAddr(rf_rdAddr0), .rf_rdVal(rf_rdVal0)
    );

    // Register file models: synchronous write, combinational read.
    logic [3:0] mem [8];
    logic [3:0] mem0 [8];
    always @(posedge clk) if (rf_wrEn) mem[rf_wrAddr] <= rf_wrVal;
    always @(posedge clk) if (rf_wrEn0) mem0[rf_wrAddr0] <= rf_wrVal0;
    assign rf_rdVal  = mem[rf_rdAddr];
    assign rf_rdVal0 = mem0[rf_rdAddr0];

    int wr_cnt0 = 0;
    always @(posedge clk) if (!rst0 && rf_wrEn0) wr_cnt0 <= wr_cnt0 + 1;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] model [8];
    logic [3:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", 8'(bus.cmd_ready), 8'h1);
    endtask

    task automatic release_and_sweep();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("sweep_wren", 8'(rf_wrEn), 8'h1);
            check("sweep_addr", 8'(rf_wrAddr), 8'(k - 1));
            check("sweep_val", 8'(rf_wrVal), 8'h5);
            check("sweep_busy", 8'(init_busy), 8'h1);
            check("sweep_ready", 8'(bus.cmd_ready), 8'h0);
        end
        tick();
        check("sweep_end_wren", 8'(rf_wrEn), 8'h0);
        check("sweep_end_busy", 8'(init_busy), 8'h0);
        check("sweep_end_ready", 8'(bus.cmd_ready), 8'h1);
        for (int a = 0; a < 8; a++) model[a] = 4'h5;
        $display("sweep done");
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [3:0] data);
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        tick();
        bus.cmd_valid = 1'b0;
        check("wr_en", 8'(rf_wrEn), 8'h1);
        check("wr_addr", 8'(rf_wrAddr), 8'(addr));
        check("wr_val", 8'(rf_wrVal), 8'(data));
        check("wr_busy_ready", 8'(bus.cmd_ready), 8'h0);
        tick();
        check("wr_done_en", 8'(rf_wrEn), 8'h0);
        check("wr_done_ready", 8'(bus.cmd_ready), 8'h1);
        model[addr] = data;
        $display("write addr=%0d data=%0h", addr, data);
    endtask

    // hold: cycles with rsp_ready low; stall_cmd keeps a write command offered meanwhile.
    task automatic do_read(input logic [2:0] addr, input int hold, input bit stall_cmd);
        logic [3:0] exp;
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = addr;
        exp_q.push_back(model[addr]);
        tick();
        bus.cmd_valid = 1'b0;
        check("rd_addr", 8'(rf_rdAddr), 8'(addr));
        check("rd_ready", 8'(bus.cmd_ready), 8'h0);
        check("rd_wren", 8'(rf_wrEn), 8'h0);
        check("rd_rsp_early", 8'(bus.rsp_valid), 8'h0);
        tick();
        check("rsp_valid", 8'(bus.rsp_valid), 8'h1);
        check("sb_nonempty", 8'(exp_q.size() != 0), 8'h1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'h0;
        check("rsp_data", 8'(bus.rsp_data), 8'(exp));
        for (int i = 0; i < hold; i++) begin
            if (stall_cmd) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_wr    = 1'b1;
                bus.cmd_addr  = addr ^ 3'd1;
                bus.cmd_data  = 4'hF;
            end
            tick();
            check("hold_valid", 8'(bus.rsp_valid), 8'h1);
            check("hold_data", 8'(bus.rsp_data), 8'(exp));
            check("hold_ready", 8'(bus.cmd_ready), 8'h0);
            check("hold_wren", 8'(rf_wrEn), 8'h0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_done_valid", 8'(bus.rsp_valid), 8'h0);
        check("rsp_done_ready", 8'(bus.cmd_ready), 8'h1);
        $display("read addr=%0d data=%0h", addr, exp);
    endtask

    initial begin
        logic [2:0] order [8];
        order = '{3'd7, 3'd0, 3'd6, 3'd1, 3'd5, 3'd2, 3'd4, 3'd3};
        bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = 3'd0;
        bus.cmd_data = 4'h0; bus.rsp_ready = 1'b0;
        bus0.cmd_valid = 1'b0; bus0.cmd_wr = 1'b0; bus0.cmd_addr = 3'd0;
        bus0.cmd_data = 4'h0; bus0.rsp_ready = 1'b0;

        // No-clear instance
        tick(); tick();
        check("c0_rst_ready", 8'(bus0.cmd_ready), 8'h0);
        check("c0_rst_busy", 8'(init_busy0), 8'h0);
        rst0 = 1'b0;
        tick();
        check("c0_first_ready", 8'(bus0.cmd_ready), 8'h1);
        check("c0_first_wren", 8'(rf_wrEn0), 8'h0);
        repeat (3) tick();
        check("c0_no_wr", 8'(wr_cnt0), 8'h0);
        bus0.cmd_valid = 1'b1; bus0.cmd_wr = 1'b1; bus0.cmd_addr = 3'd6; bus0.cmd_data = 4'h9;
        tick();
        bus0.cmd_valid = 1'b0;
        check("c0_wr_en", 8'(rf_wrEn0), 8'h1);
        check("c0_wr_addr", 8'(rf_wrAddr0), 8'h6);
        check("c0_wr_val", 8'(rf_wrVal0), 8'h9);
        tick();
        check("c0_wr_done", 8'(bus0.cmd_ready), 8'h1);
        repeat (2) tick();
        check("c0_wr_count", 8'(wr_cnt0), 8'h1);
        $display("c0 write addr=6 data=9");

        // Reset values of the clearing instance
        check("rst_ready", 8'(bus.cmd_ready), 8'h0);
        check("rst_rsp_valid", 8'(bus.rsp_valid), 8'h0);
        check("rst_rsp_data", 8'(bus.rsp_data), 8'h0);
        check("rst_wren", 8'(rf_wrEn), 8'h0);
        check("rst_wraddr", 8'(rf_wrAddr), 8'h0);
        check("rst_wrval", 8'(rf_wrVal), 8'h0);
        check("rst_rdaddr", 8'(rf_rdAddr), 8'h0);
        check("rst_busy", 8'(init_busy), 8'h1);
        release_and_sweep();
        for (int a = 0; a < 8; a++) do_read(3'(a), 0, 1'b0);

        // Read-after-write
        do_write(3'd3, 4'hA);
        do_read(3'd3, 0, 1'b0);

        // Fill and scrambled readback
        for (int a = 0; a < 8; a++) do_write(3'(a), 4'(a + 1));
        for (int i = 0; i < 8; i++) do_read(order[i], 0, 1'b0);

        // Response stall with a command offered meanwhile
        do_read(3'd4, 5, 1'b1);
        do_read(3'd5, 0, 1'b0);

        // Reset during INIT cycle 4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("init4_addr", 8'(rf_wrAddr), 8'h3);
        rst = 1'b1;
        tick();
        check("init_rst_wren", 8'(rf_wrEn), 8'h0);
        check("init_rst_ready", 8'(bus.cmd_ready), 8'h0);
        check("init_rst_valid", 8'(bus.rsp_valid), 8'h0);
        check("init_rst_busy", 8'(init_busy), 8'h1);
        release_and_sweep();

        // Reset during RESP
        do_write(3'd2, 4'hC);
        wait_ready();
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 3'd2;
        exp_q.push_back(model[2]);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("resp_before_rst", 8'(bus.rsp_valid), 8'h1);
        rst = 1'b1;
        tick();
        check("resp_rst_valid", 8'(bus.rsp_valid), 8'h0);
        check("resp_rst_ready", 8'(bus.cmd_ready), 8'h0);
        check("resp_rst_data", 8'(bus.rsp_data), 8'h0);
        exp_q.delete();
        $display("response discarded by reset");
        release_and_sweep();
        do_read(3'd2, 0, 1'b0);
        check("sb_drained", 8'(exp_q.size()), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
